// File: rtl/qc_enc_pkg.sv
// rtl/qc_enc_pkg.sv - shared types, defaults and helpers for the QC-LDPC encoder front end
package qc_enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_B = 8;
    localparam int DEFAULT_K = 4;

    // Widest circulant the rotate helper supports; callers zero-extend into it.
    localparam int MAX_B  = 64;
    localparam int MAX_BW = $clog2(MAX_B);

    // Cyclic right shift by one of the low (msb+1) bits of v; bits above msb stay zero.
    function automatic logic [MAX_B-1:0] rotr1(input logic [MAX_B-1:0] v,
                                               input logic [MAX_BW-1:0] msb);
        logic [MAX_B-1:0] r;
        r      = v >> 1;
        r[msb] = v[0];
        return r;
    endfunction

endpackage

// File: rtl/gf2_mac_row.sv
// rtl/gf2_mac_row.sv - B-wide GF(2) multiply-add row: w = w0 ^ (si & f)
module gf2_mac_row #(
    parameter int B = 8
) (
    input  logic [B-1:0] w0,
    input  logic         si,
    input  logic [B-1:0] f,
    output logic [B-1:0] w
);

    // One AND/XOR cell per bit; no carries in GF(2).
    always_comb begin
        w = w0 ^ ({B{si}} & f);
    end

endmodule

// File: rtl/qc_sraa_parity_accumulator.sv
// rtl/qc_sraa_parity_accumulator.sv - SRAA parity accumulator front end of the QC-LDPC encoder
module qc_sraa_parity_accumulator
    import qc_enc_pkg::*;
#(
    parameter int B  = DEFAULT_B,
    parameter int K  = DEFAULT_K,
    parameter int CW = $clog2(B),
    parameter int KW = (K > 1) ? $clog2(K) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         gen_req,
    input  logic         gen_valid,
    input  logic [B-1:0] gen_row,
    input  logic         msg_valid,
    input  logic         msg_bit,
    output logic         msg_ready,
    output logic [B-1:0] parity,
    output logic         parity_valid,
    input  logic         parity_ready,
    output logic         busy
);

    localparam logic [CW-1:0] BIT_LAST = CW'(B - 1);
    localparam logic [KW-1:0] BLK_LAST = KW'(K - 1);

    state_t        state;
    logic [B-1:0]  g;
    logic [B-1:0]  acc;
    logic [B-1:0]  mac_out;
    logic [CW-1:0] bit_cnt;
    logic [KW-1:0] blk_cnt;

    gf2_mac_row #(.B(B)) u_mac (
        .w0 (acc),
        .si (msg_bit),
        .f  (g),
        .w  (mac_out)
    );

    // acc is itself a register, so parity is registered and tracks acc in every state.
    assign parity = acc;

    // FSM, counters, generator shift register and accumulator; outputs are set on transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            g            <= '0;
            acc          <= '0;
            bit_cnt      <= '0;
            blk_cnt      <= '0;
            gen_req      <= 1'b0;
            msg_ready    <= 1'b0;
            parity_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        blk_cnt <= '0;
                        state   <= LOAD;
                        gen_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (gen_valid) begin
                        g         <= gen_row;
                        bit_cnt   <= '0;
                        state     <= ACCUM;
                        gen_req   <= 1'b0;
                        msg_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (msg_valid) begin
                        acc     <= mac_out;
                        g       <= B'(rotr1(MAX_B'(g), MAX_BW'(B - 1)));
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            msg_ready <= 1'b0;
                            if (blk_cnt == BLK_LAST) begin
                                state        <= DONE;
                                parity_valid <= 1'b1;
                            end else begin
                                blk_cnt <= blk_cnt + KW'(1);
                                state   <= LOAD;
                                gen_req <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    // A start arriving together with the handshake is dropped: IDLE is not yet current.
                    if (parity_ready) begin
                        state        <= IDLE;
                        parity_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qc_sraa_parity_accumulator.sv
// tb/tb_qc_sraa_parity_accumulator.sv - directed self-checking bench for the SRAA parity accumulator
module tb_qc_sraa_parity_accumulator;

    localparam int B = 8;
    localparam int K = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         gen_req;
    logic         gen_valid;
    logic [B-1:0] gen_row;
    logic         msg_valid;
    logic         msg_bit;
    logic         msg_ready;
    logic [B-1:0] parity;
    logic         parity_valid;
    logic         parity_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    qc_sraa_parity_accumulator #(.B(B), .K(K)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .gen_req      (gen_req),
        .gen_valid    (gen_valid),
        .gen_row      (gen_row),
        .msg_valid    (msg_valid),
        .msg_bit      (msg_bit),
        .msg_ready    (msg_ready),
        .parity       (parity),
        .parity_valid (parity_valid),
        .parity_ready (parity_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gen_req"},      32'(gen_req),      32'h0);
        check({tag, "_msg_ready"},    32'(msg_ready),    32'h0);
        check({tag, "_parity_valid"}, 32'(parity_valid), 32'h0);
        check({tag, "_busy"},         32'(busy),         32'h0);
        check({tag, "_parity"},       32'(parity),       32'h0);
    endtask

    // Start a codeword; a message bit offered during LOAD must not be consumed.
    task automatic do_start();
        start = 1'b1;
        step();
        start     = 1'b0;
        msg_valid = 1'b1;
        msg_bit   = 1'b1;
        step();
        msg_valid = 1'b0;
        check("start_acc_clear", 32'(parity),  32'h0);
        check("start_gen_req",   32'(gen_req), 32'h1);
        check("start_busy",      32'(busy),    32'h1);
    endtask

    task automatic load_row(input logic [B-1:0] row);
        check("load_gen_req", 32'(gen_req), 32'h1);
        gen_valid = 1'b1;
        gen_row   = row;
        step();
        gen_valid = 1'b0;
        check("load_msg_ready", 32'(msg_ready), 32'h1);
    endtask

    // bits[i] is the i-th message bit sent in the block.
    task automatic send_bits(input logic [B-1:0] bits, input int nbits, input int max_gap);
        for (int i = 0; i < nbits; i++) begin
            int gaps;
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int j = 0; j < gaps; j++) begin
                msg_valid = 1'b0;
                step();
                check("gap_msg_ready", 32'(msg_ready), 32'h1);
            end
            msg_valid = 1'b1;
            msg_bit   = bits[i];
            step();
            msg_valid = 1'b0;
        end
    endtask

    task automatic run_to_done(input logic [B-1:0] row0, input logic [B-1:0] bits0,
                               input logic [B-1:0] row1, input logic [B-1:0] bits1,
                               input int max_gap, input logic [B-1:0] exp_par, input string tag);
        do_start();
        load_row(row0);
        send_bits(bits0, B, max_gap);
        load_row(row1);
        send_bits(bits1, B, max_gap);
        check({tag, "_parity"},       32'(parity),       32'(exp_par));
        check({tag, "_parity_valid"}, 32'(parity_valid), 32'h1);
        check({tag, "_busy"},         32'(busy),         32'h1);
        check({tag, "_msg_ready"},    32'(msg_ready),    32'h0);
    endtask

    task automatic handshake(input logic [B-1:0] exp_par, input string tag);
        parity_ready = 1'b1;
        step();
        parity_ready = 1'b0;
        check({tag, "_hs_busy"},   32'(busy),         32'h0);
        check({tag, "_hs_pvalid"}, 32'(parity_valid), 32'h0);
        check({tag, "_hs_retain"}, 32'(parity),       32'(exp_par));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        gen_valid    = 1'b0;
        gen_row      = '0;
        msg_valid    = 1'b0;
        msg_bit      = 1'b0;
        parity_ready = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Single one in the row walks all positions.
        run_to_done(8'h01, 8'hFF, 8'h00, 8'h00, 0, 8'hFF, "t1");
        handshake(8'hFF, "t1");

        // First bit picks the row itself; second bit picks the row rotated once.
        run_to_done(8'h03, 8'h01, 8'h00, 8'h00, 0, 8'h03, "t2a");
        handshake(8'h03, "t2a");
        run_to_done(8'h03, 8'h02, 8'h00, 8'h00, 0, 8'h81, "t2b");
        handshake(8'h81, "t2b");

        // Cancellation across blocks, with and without gaps.
        run_to_done(8'h01, 8'h01, 8'h01, 8'h01, 0, 8'h00, "t3");
        handshake(8'h00, "t3");
        run_to_done(8'h01, 8'h01, 8'h01, 8'h01, 3, 8'h00, "t3gap");
        handshake(8'h00, "t3gap");
        // Gaps with a non-trivial result: 0x5A then row 0x0F with bits 1,1 -> 0x0F ^ 0x87 = 0x88; total 0x5A ^ 0x88.
        run_to_done(8'h5A, 8'h01, 8'h0F, 8'h03, 2, 8'hD2, "t3mix");
        handshake(8'hD2, "t3mix");

        // Stall in DONE while start and gen_valid are pulsed.
        run_to_done(8'h01, 8'hFF, 8'h00, 8'h00, 0, 8'hFF, "t4");
        for (int c = 0; c < 10; c++) begin
            start     = (c == 2);
            gen_valid = (c == 5);
            gen_row   = 8'hAA;
            step();
            start     = 1'b0;
            gen_valid = 1'b0;
            check("t4_hold_parity", 32'(parity),       32'hFF);
            check("t4_hold_pvalid", 32'(parity_valid), 32'h1);
            check("t4_hold_gen_req", 32'(gen_req),     32'h0);
        end
        // Start coinciding with the handshake is dropped.
        start = 1'b1;
        handshake(8'hFF, "t4");
        start = 1'b0;
        check("t4_start_ignored", 32'(gen_req), 32'h0);

        // Back-to-back: start one cycle after the handshake; result independent of previous FF.
        run_to_done(8'h01, 8'h01, 8'h00, 8'h00, 0, 8'h01, "t6");
        handshake(8'h01, "t6");

        // Asynchronous reset in the middle of block 1.
        do_start();
        load_row(8'h01);
        send_bits(8'hFF, B, 0);
        load_row(8'h00);
        send_bits(8'hFF, 5, 0);
        check("t5_pre_parity", 32'(parity), 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_to_done(8'h01, 8'hFF, 8'h00, 8'h00, 0, 8'hFF, "t5");
        handshake(8'hFF, "t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
